mac_feeder: RTL and testbench
=============================

# mac_feeder

Sequencer directly upstream of the MAC unit in the neuron datapath. It accepts a vector length, streams activation/weight pairs from a valid/ready source into the MAC, and drives the MAC's enable and accumulator-clear strobes. After the last product has been accumulated, it captures the MAC output and overflow flag and presents them as a held result on a valid/ready port. One dot product runs at a time.

## Interface
- DATA_WIDTH, 8, width of activation and weight operands
- OUTPUT_WIDTH, 16, width of the MAC result captured and returned
- LEN_WIDTH, 8, width of the vector-length field (max N = 2^LEN_WIDTH-1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a dot product; sampled only in IDLE
- cfg_len  in  LEN_WIDTH  number of pairs N, latched on accepted start
- busy  out  1  high in every state except IDLE
- s_valid  in  1  source pair valid
- s_ready  out  1  feeder accepts a pair; high only in RUN
- s_data  in  DATA_WIDTH  activation
- s_weight  in  DATA_WIDTH  weight
- mac_enable  out  1  to MAC enable; equals s_valid & s_ready
- mac_clear  out  1  to MAC clear_acc
- mac_data, mac_weight  out  DATA_WIDTH  combinational pass-through of s_data, s_weight
- mac_valid  in  1  MAC valid (enable delayed one cycle)
- mac_out  in  OUTPUT_WIDTH  MAC accumulator low bits
- mac_overflow  in  1  MAC sticky overflow
- res_valid  out  1  result available, held until accepted
- res_ready  in  1  consumer accepts result
- res_data  out  OUTPUT_WIDTH  captured dot product
- res_overflow  out  1  captured overflow flag
- done  out  1  one-cycle pulse on the result handshake

## Operation
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE: if start=1 and cfg_len!=0, latch N=cfg_len, clear beat counter, set first_flag, go to RUN. If start=1 and cfg_len=0, assert mac_clear (mac_enable=0) for that cycle, load res_data=0 and res_overflow=0, go to HOLD. Any other start is ignored.
- RUN: s_ready=1. Each beat (s_valid=1) asserts mac_enable. mac_clear=1 on the first beat only, so the MAC loads the product and clears its overflow flag. The counter increments per beat. Gaps in s_valid insert idle cycles with mac_enable=0. On beat N, go to DRAIN.
- DRAIN: s_ready=0. In this cycle mac_valid=1 and mac_out holds the final sum. Register mac_out into res_data and mac_overflow into res_overflow, then go to HOLD. If mac_valid=0 in DRAIN, which is a protocol error, the feeder stays in DRAIN until mac_valid=1.
- HOLD: res_valid=1, and res_data and res_overflow stay stable. On res_ready=1, pulse done, go to IDLE. start is ignored.
- mac_clear is 0 outside the first RUN beat and the zero-length start cycle.
- Counter width is LEN_WIDTH. The last-beat compare uses counter==N-1 at acceptance. No wrap occurs because N is at most 2^LEN_WIDTH-1.

## Timing
- Reset values: state=IDLE; busy, s_ready, mac_enable, mac_clear, res_valid, res_overflow, done = 0; res_data=0. mac_data and mac_weight follow their inputs.
- start accepted in cycle 0 puts RUN in cycle 1, with s_ready high from cycle 1.
- With back-to-back beats in cycles 1..N: DRAIN in cycle N+1, res_valid=1 from cycle N+2. Latency from last beat to res_valid is 2 cycles.
- done is high in the cycle after the res_valid&res_ready handshake, coinciding with state=IDLE. A new start is accepted in that same cycle.
- Asserting rst_n low at any point, including mid-RUN, returns to IDLE immediately with all outputs at reset values. Pending beats and results are dropped.

## Configuration
- MAC_FEEDER_SAT_EN defined: in DRAIN, if mac_overflow=1, res_data is loaded with all ones (0xFFFF at OUTPUT_WIDTH=16) and res_overflow=1.
- MAC_FEEDER_SAT_EN undefined: res_data=mac_out unconditionally, and res_overflow still reflects mac_overflow.

## Test plan
- Bench drives a cycle-accurate MAC model on the mac_* ports. Run N=3 with pairs (2,3),(4,5),(10,10) back-to-back -> mac_clear high only on beat 1, res_data=0x007E, res_valid from cycle 5, done pulses after res_ready.
- Follow immediately with N=1 and pair (7,8) -> accumulator reloads via mac_clear, res_data=0x0038 with no residue from the previous job.
- N=4 with s_valid low for 3 cycles between beats 2 and 3, and res_ready low for 5 cycles in HOLD -> mac_enable only on the 4 beats, res_data held stable, start ignored while busy.
- start with cfg_len=0 -> one-cycle mac_clear, res_valid next cycle, res_data=0, res_overflow=0.
- Model forces mac_overflow=1 in DRAIN with mac_out=0x1234 -> with MAC_FEEDER_SAT_EN: res_data=0xFFFF and res_overflow=1; without it: res_data=0x1234 and res_overflow=1.
- Assert rst_n low after beat 2 of N=5 -> s_ready, busy, and res_valid are 0 immediately; after release, a fresh N=2 job (1,1),(1,1) returns 0x0002.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder
// Sequencer sitting directly in front of the MAC unit. It accepts a vector
// length, streams activation/weight pairs from a valid/ready source into the
// MAC, and drives the MAC enable and accumulator-clear strobes. When the MAC
// reports the final sum, it captures the sum and the overflow flag and holds
// them on a valid/ready result port until the consumer takes them. Only one
// dot product is in flight at a time.
//
// Optional feature macro: MAC_FEEDER_SAT_EN
//   defined   -> a captured overflow saturates res_data to all ones
//   undefined -> res_data is the raw MAC output
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, cfg_len        begin a job of cfg_len pairs (sampled in IDLE only)
//   busy                  high whenever a job is in progress
//   s_valid/s_ready       source handshake for (s_data, s_weight)
//   mac_enable, mac_clear strobes to the MAC
//   mac_data, mac_weight  operands passed straight through to the MAC
//   mac_valid, mac_out,   MAC result, valid one cycle after enable
//   mac_overflow
//   res_valid/res_ready   result handshake for (res_data, res_overflow)
//   done                  one-cycle pulse in the cycle after the result handshake
module mac_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    output logic                    busy,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH-1:0]   s_weight,
    output logic                    mac_enable,
    output logic                    mac_clear,
    output logic [DATA_WIDTH-1:0]   mac_data,
    output logic [DATA_WIDTH-1:0]   mac_weight,
    input  logic                    mac_valid,
    input  logic [OUTPUT_WIDTH-1:0] mac_out,
    input  logic                    mac_overflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUTPUT_WIDTH-1:0] res_data,
    output logic                    res_overflow,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                  state;
    state_t                  state_next;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [OUTPUT_WIDTH-1:0] res_data_q;
    logic                    res_ovf_q;
    logic                    done_q;

    logic                    beat;
    logic                    last_beat;
    logic                    zero_start;
    logic [OUTPUT_WIDTH-1:0] cap_data;

    // A beat is an accepted source pair; the counter still reads N-1 on the
    // beat that completes the vector, so no extra cycle is needed to detect it.
    assign beat       = s_valid && (state == RUN);
    assign last_beat  = beat && (cnt_q == (len_q - LEN_ONE));
    assign zero_start = (state == IDLE) && start && (cfg_len == '0);

    // Operands never pass through a register, so the MAC sees a pair in the
    // same cycle its enable is raised.
    assign mac_data     = s_data;
    assign mac_weight   = s_weight;
    assign s_ready      = (state == RUN);
    assign mac_enable   = beat;
    // The first beat clears the accumulator so it loads the product instead
    // of adding to the previous job's residue; an empty job clears it too.
    assign mac_clear    = zero_start || (beat && (cnt_q == '0));
    assign busy         = (state != IDLE);
    assign res_valid    = (state == HOLD);
    assign res_data     = res_data_q;
    assign res_overflow = res_ovf_q;
    assign done         = done_q;

    // Value stored into res_data when the MAC presents its final sum.
`ifdef MAC_FEEDER_SAT_EN
    assign cap_data = mac_overflow ? {OUTPUT_WIDTH{1'b1}} : mac_out;
`else
    assign cap_data = mac_out;
`endif

    // Next-state decode. DRAIN waits for mac_valid rather than assuming it,
    // so a misbehaving MAC stalls the feeder instead of corrupting a result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cfg_len != '0) ? RUN : HOLD;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (mac_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, job length, beat counter, captured result and the done pulse.
    // An empty job loads a zero result directly so HOLD presents it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == HOLD) && res_ready;
            case (state)
                IDLE: begin
                    if (start && (cfg_len != '0)) begin
                        len_q <= cfg_len;
                        cnt_q <= '0;
                    end else if (zero_start) begin
                        res_data_q <= '0;
                        res_ovf_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (beat) begin
                        cnt_q <= cnt_q + LEN_ONE;
                    end
                end
                DRAIN: begin
                    if (mac_valid) begin
                        res_data_q <= cap_data;
                        res_ovf_q  <= mac_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
// Self-checking bench for mac_feeder. A cycle-accurate MAC model hangs off
// the mac_* ports; expected results come from summing the products of each
// job with plain integer arithmetic. Directed jobs follow the intended usage
// scenarios, then randomized jobs with random gaps and consumer stalls.
//
// Ports of the DUT are all driven/observed here; no ports of its own.
module tb_mac_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        busy;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [7:0]  s_weight;
    logic        mac_enable;
    logic        mac_clear;
    logic [7:0]  mac_data;
    logic [7:0]  mac_weight;
    logic        mac_valid;
    logic [15:0] mac_out;
    logic        mac_overflow;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_overflow;
    logic        done;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [7:0]  pd [0:255];
    logic [7:0]  pw [0:255];
    logic        ovr = 1'b0;

    logic [15:0] acc;
    logic        acc_ovf;

    mac_feeder #(
        .DATA_WIDTH  (8),
        .OUTPUT_WIDTH(16),
        .LEN_WIDTH   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_len     (cfg_len),
        .busy        (busy),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_weight    (s_weight),
        .mac_enable  (mac_enable),
        .mac_clear   (mac_clear),
        .mac_data    (mac_data),
        .mac_weight  (mac_weight),
        .mac_valid   (mac_valid),
        .mac_out     (mac_out),
        .mac_overflow(mac_overflow),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_overflow(res_overflow),
        .done        (done)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC model: accumulates on enable, reloads on clear, sticky overflow on
    // carry out of 16 bits, valid one cycle after enable. While ovr is set,
    // it reports a fixed overflowing result to exercise the overflow path.
    always @(posedge clk or negedge rst_n) begin : mac_model
        logic [16:0] sum;
        if (!rst_n) begin
            acc       <= '0;
            acc_ovf   <= 1'b0;
            mac_valid <= 1'b0;
        end else begin
            mac_valid <= mac_enable;
            if (mac_enable) begin
                sum = (mac_clear ? 17'd0 : {1'b0, acc}) + 17'(mac_data * mac_weight);
                acc     <= sum[15:0];
                acc_ovf <= (mac_clear ? 1'b0 : acc_ovf) | sum[16];
            end
        end
    end

    assign mac_out      = ovr ? 16'h1234 : acc;
    assign mac_overflow = ovr ? 1'b1 : acc_ovf;

    // One comparison; counts it and reports failures with the tag.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs at the falling edge and let combinational
    // outputs settle before the caller looks at them.
    task automatic applyStimulus(input logic st, input logic [7:0] len, input logic sv,
                                 input logic [7:0] d, input logic [7:0] w, input logic rr);
        @(negedge clk);
        start     = st;
        cfg_len   = len;
        s_valid   = sv;
        s_data    = d;
        s_weight  = w;
        res_ready = rr;
        #1;
    endtask

    // One complete job from start to result handshake. gap_at inserts gap_len
    // empty cycles before that beat (with start raised, which must be ignored);
    // hold_wait stalls the consumer that many cycles in HOLD.
    task automatic runJob(input int n, input int gap_at, input int gap_len, input int hold_wait,
                          input logic exp_done, input string tag);
        longint      total = 0;
        logic [15:0] exp_data;
        logic        exp_ovf;
        applyStimulus(1'b1, n[7:0], 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        checkOutput({tag, ".done_at_start"}, done, exp_done);
        checkOutput({tag, ".idle_busy"}, busy, 0);
        checkOutput({tag, ".start_clear"}, mac_clear, (n == 0));
        checkOutput({tag, ".start_enable"}, mac_enable, 0);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    applyStimulus(1'b1, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'b0);
                    checkOutput({tag, ".gap_enable"}, mac_enable, 0);
                    checkOutput({tag, ".gap_ready"}, s_ready, 1);
                end
            end
            applyStimulus(1'b0, 8'd0, 1'b1, pd[i], pw[i], 1'b0);
            checkOutput({tag, ".beat_enable"}, mac_enable, 1);
            checkOutput({tag, ".beat_clear"}, mac_clear, (i == 0));
            checkOutput({tag, ".beat_data"}, {mac_data, mac_weight}, {pd[i], pw[i]});
            total += longint'(pd[i]) * longint'(pw[i]);
        end
        if (n > 0) begin
            applyStimulus(1'b1, 8'd3, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
            checkOutput({tag, ".drain_ready"}, s_ready, 0);
            checkOutput({tag, ".drain_enable"}, mac_enable, 0);
            checkOutput({tag, ".drain_res_valid"}, res_valid, 0);
            checkOutput({tag, ".drain_busy"}, busy, 1);
        end
        exp_data = total[15:0];
        exp_ovf  = (total > 65535);
        if (ovr) begin
            exp_data = 16'h1234;
            exp_ovf  = 1'b1;
        end
`ifdef MAC_FEEDER_SAT_EN
        if (exp_ovf) exp_data = 16'hFFFF;
`endif
        for (int h = 0; h <= hold_wait; h++) begin
            applyStimulus(1'b1, 8'd0, 1'b0, 8'($urandom), 8'($urandom), (h == hold_wait));
            checkOutput({tag, ".res_valid"}, res_valid, 1);
            checkOutput({tag, ".res_data"}, res_data, exp_data);
            checkOutput({tag, ".res_overflow"}, res_overflow, exp_ovf);
            checkOutput({tag, ".hold_clear"}, mac_clear, 0);
            checkOutput({tag, ".hold_done"}, done, 0);
        end
    endtask

    initial begin
        int n;
        int ga;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = 8'd0;
        s_valid   = 1'b1;
        s_data    = 8'hA5;
        s_weight  = 8'h3C;
        res_ready = 1'b0;
        #2;
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.s_ready", s_ready, 0);
        checkOutput("reset.mac_enable", mac_enable, 0);
        checkOutput("reset.mac_clear", mac_clear, 0);
        checkOutput("reset.res_valid", res_valid, 0);
        checkOutput("reset.res_data", res_data, 0);
        checkOutput("reset.res_overflow", res_overflow, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.passthru", {mac_data, mac_weight}, 16'hA53C);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);

        $display("[TB] directed: N=3 back-to-back");
        pd[0] = 8'd2;  pw[0] = 8'd3;
        pd[1] = 8'd4;  pw[1] = 8'd5;
        pd[2] = 8'd10; pw[2] = 8'd10;
        runJob(3, -1, 0, 0, 1'b0, "n3");

        $display("[TB] directed: N=1 immediately after");
        pd[0] = 8'd7; pw[0] = 8'd8;
        runJob(1, -1, 0, 0, 1'b1, "n1");

        $display("[TB] directed: N=4 with source gap and consumer stall");
        for (int i = 0; i < 4; i++) begin
            pd[i] = 8'(i + 9);
            pw[i] = 8'(3 * i + 1);
        end
        runJob(4, 2, 3, 5, 1'b1, "n4gap");

        $display("[TB] directed: zero-length job");
        runJob(0, -1, 0, 1, 1'b1, "n0");

        $display("[TB] directed: forced MAC overflow");
        ovr = 1'b1;
        pd[0] = 8'd1; pw[0] = 8'd1;
        pd[1] = 8'd2; pw[1] = 8'd2;
        runJob(2, -1, 0, 0, 1'b1, "ovr");
        ovr = 1'b0;

        $display("[TB] directed: natural accumulator overflow");
        for (int i = 0; i < 4; i++) begin
            pd[i] = 8'($urandom_range(200, 255));
            pw[i] = 8'($urandom_range(200, 255));
        end
        runJob(4, 1, 2, 1, 1'b1, "natovf");

        $display("[TB] random jobs");
        for (int j = 0; j < 8; j++) begin
            n  = $urandom_range(1, 12);
            ga = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            for (int i = 0; i < n; i++) begin
                pd[i] = 8'($urandom);
                pw[i] = 8'($urandom);
            end
            runJob(n, ga, $urandom_range(1, 3), $urandom_range(0, 3), 1'b1, "rand");
        end

        $display("[TB] directed: reset in the middle of a job");
        applyStimulus(1'b1, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("rst.done_at_start", done, 1);
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd9, 8'd9, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd9, 8'd9, 1'b0);
        checkOutput("rst.pre_ready", s_ready, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.s_ready", s_ready, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.res_valid", res_valid, 0);
        checkOutput("rst.mac_enable", mac_enable, 0);
        checkOutput("rst.res_data", res_data, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        pd[0] = 8'd1; pw[0] = 8'd1;
        pd[1] = 8'd1; pw[1] = 8'd1;
        runJob(2, -1, 0, 0, 1'b0, "post_rst");
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("final.done", done, 1);
        checkOutput("final.busy", busy, 0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("final.done_pulse", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
